// File: rtl/page_buf_arbiter.sv
// page_buf_arbiter
//   Owns the shared page buffer between the host port and the flash
//   controller port. One requester at a time is granted and beats are
//   counted up to BUF_DEPTH. The arbiter tracks whose data the buffer holds
//   (content), so only coherent transfers are granted: a writer needs an
//   empty buffer, and a reader needs the other side's data.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   host_req/dir/beat                host request level, direction (1 = write), beat strobe
//   host_gnt/done/err                host grant, 1-cycle completion and error pulses
//   ctrl_req/dir/beat                controller request level, direction (1 = write), beat strobe
//   ctrl_gnt/done/err                controller grant, 1-cycle completion and error pulses
//   buf_sel/we/re                    host-side buffer strobes
//   cntrl_sel/we/re                  controller-side buffer strobes
//   beat_cnt                         beats completed in the current grant
//   content                          0 EMPTY, 1 HOST_DATA, 2 FLASH_DATA
module page_buf_arbiter #(
    parameter int BUF_DEPTH = 2048,
    parameter int CNT_W     = 12,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_req,
    input  logic             host_dir,
    input  logic             host_beat,
    output logic             host_gnt,
    output logic             host_done,
    output logic             host_err,
    input  logic             ctrl_req,
    input  logic             ctrl_dir,
    input  logic             ctrl_beat,
    output logic             ctrl_gnt,
    output logic             ctrl_done,
    output logic             ctrl_err,
    output logic             buf_sel,
    output logic             buf_we,
    output logic             buf_re,
    output logic             cntrl_sel,
    output logic             cntrl_we,
    output logic             cntrl_re,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [1:0]       content
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_GRANT_HOST = 2'd1,
        S_GRANT_CTRL = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    localparam logic [1:0] C_EMPTY = 2'd0;
    localparam logic [1:0] C_HOST  = 2'd1;
    localparam logic [1:0] C_FLASH = 2'd2;

    localparam int               TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BUF_DEPTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        content_q, content_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic              dir_q, dir_d;
    logic              rr_last_q, rr_last_d;     // 1 = controller was granted last
    logic              host_blk_q, host_blk_d;   // set after an illegal request until req drops
    logic              ctrl_blk_q, ctrl_blk_d;
    logic              host_done_q, host_done_d;
    logic              host_err_q, host_err_d;
    logic              ctrl_done_q, ctrl_done_d;
    logic              ctrl_err_q, ctrl_err_d;

    logic host_legal, ctrl_legal;
    logic host_go, ctrl_go;
    logic act_host, act_req, act_beat;

    always_comb begin
        state_d     = state_q;
        content_d   = content_q;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        dir_d       = dir_q;
        rr_last_d   = rr_last_q;
        // A blocked requester is re-armed only once it drops its request.
        host_blk_d  = host_blk_q & host_req;
        ctrl_blk_d  = ctrl_blk_q & ctrl_req;
        host_done_d = 1'b0;
        host_err_d  = 1'b0;
        ctrl_done_d = 1'b0;
        ctrl_err_d  = 1'b0;

        host_legal = host_dir ? (content_q == C_EMPTY) : (content_q == C_FLASH);
        ctrl_legal = ctrl_dir ? (content_q == C_EMPTY) : (content_q == C_HOST);
        host_go    = host_req & ~host_blk_q & host_legal;
        ctrl_go    = ctrl_req & ~ctrl_blk_q & ctrl_legal;

        // Signals of whichever port currently owns the buffer.
        act_host = (state_q == S_GRANT_HOST);
        act_req  = act_host ? host_req  : ctrl_req;
        act_beat = act_host ? host_beat : ctrl_beat;

        case (state_q)
            S_IDLE: begin
                beat_cnt_d = '0;
                idle_cnt_d = '0;
                if (host_req && !host_blk_q && !host_legal) begin
                    host_err_d = 1'b1;
                    host_blk_d = 1'b1;
                end
                if (ctrl_req && !ctrl_blk_q && !ctrl_legal) begin
                    ctrl_err_d = 1'b1;
                    ctrl_blk_d = 1'b1;
                end
                // On a tie the port that was not granted last wins.
                if (host_go && (!ctrl_go || rr_last_q)) begin
                    state_d   = S_GRANT_HOST;
                    dir_d     = host_dir;
                    rr_last_d = 1'b0;
                end else if (ctrl_go) begin
                    state_d   = S_GRANT_CTRL;
                    dir_d     = ctrl_dir;
                    rr_last_d = 1'b1;
                end
            end

            S_GRANT_HOST, S_GRANT_CTRL: begin
                if (!act_req || (!act_beat && idle_cnt_q == TO_LAST)) begin
                    // Abort: the partial page is discarded.
                    state_d    = S_DONE;
                    content_d  = C_EMPTY;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    host_err_d = act_host;
                    ctrl_err_d = ~act_host;
                end else if (act_beat) begin
                    idle_cnt_d = '0;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d     = S_DONE;
                        beat_cnt_d  = '0;
                        host_done_d = act_host;
                        ctrl_done_d = ~act_host;
                        if (!dir_q)        content_d = C_EMPTY;
                        else if (act_host) content_d = C_HOST;
                        else               content_d = C_FLASH;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                end
            end

            S_DONE: begin
                state_d    = S_IDLE;
                beat_cnt_d = '0;
                idle_cnt_d = '0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            content_q   <= C_EMPTY;
            beat_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            dir_q       <= 1'b0;
            rr_last_q   <= 1'b1;
            host_blk_q  <= 1'b0;
            ctrl_blk_q  <= 1'b0;
            host_done_q <= 1'b0;
            host_err_q  <= 1'b0;
            ctrl_done_q <= 1'b0;
            ctrl_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            content_q   <= content_d;
            beat_cnt_q  <= beat_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            dir_q       <= dir_d;
            rr_last_q   <= rr_last_d;
            host_blk_q  <= host_blk_d;
            ctrl_blk_q  <= ctrl_blk_d;
            host_done_q <= host_done_d;
            host_err_q  <= host_err_d;
            ctrl_done_q <= ctrl_done_d;
            ctrl_err_q  <= ctrl_err_d;
        end
    end

    assign host_gnt  = (state_q == S_GRANT_HOST);
    assign ctrl_gnt  = (state_q == S_GRANT_CTRL);
    assign host_done = host_done_q;
    assign host_err  = host_err_q;
    assign ctrl_done = ctrl_done_q;
    assign ctrl_err  = ctrl_err_q;

    // Strobes use the direction latched at grant time.
    assign buf_sel   = host_gnt;
    assign buf_we    = host_gnt & dir_q & host_beat;
    assign buf_re    = host_gnt & ~dir_q & host_beat;
    assign cntrl_sel = ctrl_gnt;
    assign cntrl_we  = ctrl_gnt & dir_q & ctrl_beat;
    assign cntrl_re  = ctrl_gnt & ~dir_q & ctrl_beat;

    assign beat_cnt  = beat_cnt_q;
    assign content   = content_q;

endmodule
